// File: rtl/mips_io_pkg.sv
// mips_io_pkg: FSM states, segment select codes and active-low 7-segment patterns (bit 0 = segment a)
package mips_io_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CONV, COMMIT} state_t;
  typedef enum logic [1:0] {SEL_DIG, SEL_BLANK, SEL_MINUS, SEL_E} seg_sel_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [111:0] SEG_HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  function automatic logic [6:0] hex_seg(input logic [3:0] c);
    return SEG_HEX[7*c +: 7];
  endfunction
endpackage

// File: rtl/output_display_port_if.sv
// output_display_port_if: processor-to-display valid/ready write channel (hex_sel present with HEX_MODE_EN)
interface output_display_port_if #(parameter int DATA_W = 32);
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef HEX_MODE_EN
  logic hex_sel;
`endif
  modport master (output out_valid, output out_data, input out_ready
`ifdef HEX_MODE_EN
    , output hex_sel
`endif
  );
  modport slave (input out_valid, input out_data, output out_ready
`ifdef HEX_MODE_EN
    , input hex_sel
`endif
  );
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: 4-bit code or blank/minus/E selection to active-low segments a..g
module seg7_decoder
  import mips_io_pkg::*;
(
  input  logic [3:0] code,
  input  seg_sel_t   sel,
  output logic [6:0] seg
);
  always_comb seg = sel == SEL_BLANK ? SEG_BLANK :
                    sel == SEL_MINUS ? SEG_MINUS :
                    sel == SEL_E     ? SEG_E     : hex_seg(code);
endmodule

// File: rtl/output_display_port.sv
// output_display_port: signed-decimal 7-segment output port with sequential double-dabble; HEX_MODE_EN adds raw hex writes
module output_display_port
  import mips_io_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  output_display_port_if.slave   bus,
  output logic [DATA_W-1:0]      disp_value,
  output logic                   neg,
  output logic                   ovf,
  output logic [6:0]             seg,
  output logic [DIGITS-1:0]      an
);
  localparam int BCD_W = 4 * (DIGITS + 2);
  localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PS_W = $clog2(SCAN_DIV + 1);
  state_t state, state_nx;
  logic [DATA_W-1:0] bin, mag;
  logic [BCD_W-1:0] bcd, bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic [4*DIGITS-1:0] dig;
  logic [DIGITS-1:0] nz;
  logic [PS_W-1:0] ps;
  logic [IDX_W-1:0] idx;
  logic sign_r, hex_r, hex_in, xfer, wrap, top;
  seg_sel_t sel;
`ifdef HEX_MODE_EN
  assign hex_in = bus.hex_sel;
`else
  assign hex_in = 1'b0;
`endif
  assign bus.out_ready = state == IDLE;
  assign xfer = bus.out_valid & bus.out_ready;
  assign mag = bus.out_data[DATA_W-1] ? -bus.out_data : bus.out_data;
  assign wrap = ps == PS_W'(SCAN_DIV - 1);
  always_comb begin
    state_nx = state == IDLE ? (xfer ? LOAD : IDLE) :
               state == LOAD ? (hex_r ? COMMIT : CONV) :
               state == CONV ? (cnt == CNT_W'(DATA_W - 1) ? COMMIT : CONV) : IDLE;
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS + 2; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      sign_r <= 1'b0;
      hex_r <= 1'b0;
      disp_value <= '0;
      dig <= '0;
      neg <= 1'b0;
      ovf <= 1'b0;
      ps <= '0;
      idx <= '0;
    end else begin
      state <= state_nx;
      ps <= wrap ? '0 : ps + 1'b1;
      if (wrap) idx <= idx == IDX_W'(DIGITS - 1) ? '0 : idx + 1'b1;
      // Capture on the transfer edge; the processor may drop out_data right after
      if (xfer) begin
        bin <= hex_in ? bus.out_data : mag;
        sign_r <= bus.out_data[DATA_W-1];
        hex_r <= hex_in;
        disp_value <= bus.out_data;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == CONV) begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        dig <= hex_r ? bin[4*DIGITS-1:0] : bcd[4*DIGITS-1:0];
        neg <= ~hex_r & sign_r;
        ovf <= ~hex_r & (|bcd[BCD_W-1:4*(DIGITS-1)]);
      end
    end
  always_comb begin
    nz = '0;
    for (int i = 0; i < DIGITS; i++) nz[i] = |dig[4*i +: 4];
  end
  assign top = idx == IDX_W'(DIGITS - 1);
  assign sel = ovf ? (top ? SEL_E : SEL_BLANK) :
               (top && neg) ? SEL_MINUS :
               (idx != '0 && (nz >> idx) == '0) ? SEL_BLANK : SEL_DIG;
  assign an = ~(DIGITS'(1) << idx);
  seg7_decoder u_dec (.code(dig[{idx, 2'b00} +: 4]), .sel(sel), .seg(seg));
endmodule

// File: tb/tb_output_display_port.sv
// tb_output_display_port: table and random writes checked against an arithmetic display model
module tb_output_display_port;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] disp_value;
  logic neg, ovf;
  logic [6:0] seg;
  logic [7:0] an;
  int vectors = 0;
  int miscompares = 0;
  logic [6:0] dec7 [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef struct {logic [31:0] data; logic neg; logic ovf;} vec_t;
  vec_t tbl [12];
  output_display_port_if #(.DATA_W(32)) bus ();
  output_display_port #(.DATA_W(32), .DIGITS(8), .SCAN_DIV(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .disp_value(disp_value),
    .neg(neg), .ovf(ovf), .seg(seg), .an(an));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic logic [6:0] mseg(input logic [31:0] w, input int d);
    longint v = longint'($signed(w));
    longint m = v < 0 ? -v : v;
    longint p = 1;
    for (int k = 0; k < d; k++) p *= 10;
    if (m > 9999999) return d == 7 ? 7'h06 : 7'h7F;
    if (d == 7) return v < 0 ? 7'h3F : 7'h7F;
    if (d > 0 && m < p) return 7'h7F;
    return dec7[int'((m / p) % 10)];
  endfunction
  task automatic check_display(input string nm, input logic [31:0] w);
    logic [6:0] got [8];
    for (int i = 0; i < 8; i++) got[i] = 'x;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if (!an[i]) got[i] = seg;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("%s seg%0d", nm, i), 64'(got[i]), 64'(mseg(w, i)));
  endtask
  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!bus.out_ready && t < 100) begin @(negedge clk); t++; end
  endtask
  task automatic run_word(input string nm, input logic [31:0] w, input logic en, input logic eo);
    int lat = 0;
    wait_ready();
    bus.out_data = w;
    bus.out_valid = 1'b1;
    @(posedge clk); #1;
    bus.out_valid = 1'b0;
    bus.out_data = $urandom;
    while (!bus.out_ready && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, 64'(lat), 64'd34);
    chk({nm, " disp_value"}, 64'(disp_value), 64'(w));
    chk({nm, " neg"}, 64'(neg), 64'(en));
    chk({nm, " ovf"}, 64'(ovf), 64'(eo));
    check_display(nm, w);
  endtask
  initial begin
    logic [31:0] w;
    longint v;
    int t;
    tbl[0] = '{32'd1234, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFB, 1'b1, 1'b0};
    tbl[2] = '{32'd100000000, 1'b0, 1'b1};
    tbl[3] = '{32'd7, 1'b0, 1'b0};
    tbl[4] = '{32'd0, 1'b0, 1'b0};
    tbl[5] = '{32'd9999999, 1'b0, 1'b0};
    tbl[6] = '{32'd10000000, 1'b0, 1'b1};
    tbl[7] = '{32'hFF676981, 1'b1, 1'b0};
    tbl[8] = '{32'h80000000, 1'b1, 1'b1};
    tbl[9] = '{32'h7FFFFFFF, 1'b0, 1'b1};
    tbl[10] = '{32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[11] = '{32'd10, 1'b0, 1'b0};
    bus.out_valid = 1'b0;
    bus.out_data = '0;
`ifdef HEX_MODE_EN
    bus.hex_sel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst ready", 64'(bus.out_ready), 64'd1);
    chk("rst disp_value", 64'(disp_value), 64'd0);
    chk("rst neg", 64'(neg), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    chk("rst an", 64'(an), 64'hFE);
    chk("rst seg", 64'(seg), 64'h40);
    reset = 1'b1;
    chk("scan 0", 64'(an), 64'hFE);
    for (int k = 1; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("scan %0d", k), 64'(an), 64'(8'hFF ^ (8'h01 << ((k / 2) % 8))));
    end
    check_display("rst", 32'd0);
    for (int i = 0; i < 12; i++) run_word($sformatf("tbl%0d", i), tbl[i].data, tbl[i].neg, tbl[i].ovf);
    // Second write presented mid-conversion must wait for out_ready
    wait_ready();
    bus.out_data = 32'd4321;
    bus.out_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_data = 32'hFFFFFF85;
    repeat (10) @(negedge clk);
    chk("hold ready", 64'(bus.out_ready), 64'd0);
    chk("hold disp_value", 64'(disp_value), 64'd4321);
    t = 0;
    while (!bus.out_ready && t < 100) begin @(negedge clk); t++; end
    chk("hold wait", 64'(t < 100), 64'd1);
    chk("hold disp before", 64'(disp_value), 64'd4321);
    chk("hold seg0 committed", 64'(an[0] ? 7'h00 : seg), 64'(an[0] ? 7'h00 : mseg(32'd4321, 0)));
    @(posedge clk); #1;
    bus.out_valid = 1'b0;
    chk("hold disp after", 64'(disp_value), 64'hFFFFFF85);
    wait_ready();
    chk("hold neg", 64'(neg), 64'd1);
    check_display("hold", 32'hFFFFFF85);
    // Reset during conversion aborts without committing
    wait_ready();
    bus.out_data = 32'd999;
    bus.out_valid = 1'b1;
    @(posedge clk); #1;
    bus.out_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort ready", 64'(bus.out_ready), 64'd1);
    chk("abort disp_value", 64'(disp_value), 64'd0);
    chk("abort an", 64'(an), 64'hFE);
    chk("abort neg", 64'(neg), 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("abort after disp", 64'(disp_value), 64'd0);
    chk("abort after ovf", 64'(ovf), 64'd0);
    check_display("abort", 32'd0);
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: w = $urandom_range(0, 9999);
        1: w = -$urandom_range(0, 9999999);
        2: w = $urandom;
        default: w = $urandom_range(9999990, 10000010);
      endcase
      v = longint'($signed(w));
      run_word($sformatf("rnd%0d", r), w, v < 0, (v < 0 ? -v : v) > 9999999);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
